rvmyth_run_ctrl: RTL and testbench
==================================

// Module: rvmyth_run_ctrl
// PURPOSE
//   Run sequencer for the rvmyth core. It sits between the top level and the core/clk_gate pair.
//   On start, it holds the core in reset with its clock enabled, then releases reset and lets the core run.
//   It watches the 10-bit core OUT bus and declares completion once OUT stops changing.
//   It then gates the core clock off and latches the result. A watchdog aborts runs that never settle.
// PARAMETERS
//   RST_CYCLES     10     cycles core_reset is held high (clock running) before release; >=1
//   STABLE_CYCLES  64     consecutive cycles core_out must stay unchanged to declare done; >=2
//   MAX_CYCLES     10000  RUN-state watchdog limit in cycles; >STABLE_CYCLES
//   CNT_W          16     counter width; 2**CNT_W > MAX_CYCLES
// PORTS
//   CLK         in   1      single clock; all logic on the rising edge
//   reset       in   1      synchronous, active-high
//   start       in   1      level, sampled each edge; begins a run from IDLE/DONE/TIMEOUT
//   abort       in   1      level; kills an active run
//   core_out    in   10     rvmyth OUT bus
//   core_reset  out  1      reset to the core
//   clk_en      out  1      enable to the core clk_gate
//   busy        out  1      high in RST_HOLD or RUN
//   done        out  1      high in DONE (level)
//   timeout     out  1      high in TIMEOUT (level)
//   result      out  10     core_out value latched on entering DONE or TIMEOUT
// BEHAVIOUR
//   - All outputs are registered.
//   - reset: state=IDLE; core_reset=1, clk_en=0, busy=0, done=0, timeout=0, result=0; all counters 0.
//   - States: IDLE, RST_HOLD, RUN, DONE, TIMEOUT.
//   - IDLE: core_reset=1, clk_en=0. start=1 -> RST_HOLD.
//   - RST_HOLD: core_reset=1, clk_en=1, busy=1; done/timeout cleared on entry.
//     - hold_cnt counts 0..RST_CYCLES-1, then -> RUN.
//     - Start sampled at edge k: core_reset is high with clk_en during edges k+1..k+RST_CYCLES.
//     - core_reset falls at edge k+1+RST_CYCLES.
//   - RUN: core_reset=0, clk_en=1, busy=1.
//     - run_cnt increments every cycle from 0.
//     - prev_out captures core_out every cycle. First RUN cycle compares against the value sampled in the last RST_HOLD cycle.
//     - stab_cnt resets to 0 when core_out!=prev_out, else increments and saturates.
//     - stab_cnt==STABLE_CYCLES-1 with core_out==prev_out -> DONE; result<=core_out.
//     - Else run_cnt==MAX_CYCLES-1 -> TIMEOUT; result<=core_out.
//     - Both conditions in the same cycle: DONE wins.
//   - DONE / TIMEOUT: clk_en=0, core_reset=0 (core state frozen, not reset), busy=0, result held.
//     start=1 -> RST_HOLD (new run; done/timeout drop on that edge).
//   - abort=1 in RST_HOLD or RUN -> IDLE next edge: core_reset=1, clk_en=0, result unchanged. abort is ignored in other states.
//   - abort and start asserted together: abort wins if busy; otherwise start is honoured.
//   - start while busy is ignored (no restart).
//   - Synchronous reset mid-run: IDLE on the next edge, same values as reset; no partial result latched.
//   - Counters never wrap: the watchdog fires first by construction (parameter rules above).
// CONFIGURATION
//   RUN_CTRL_CYCLE_COUNT_EN
//     - Defined: adds output cycle_count [CNT_W-1:0]. It equals the number of RUN cycles of the last completed or timed-out run.
//       It is latched with result, reset to 0, and unchanged by abort.
//     - Undefined: the port and its register are absent; all other behaviour is identical.
// TESTING
//   (bench params RST_CYCLES=4, STABLE_CYCLES=8, MAX_CYCLES=100 unless noted)
//   - Reset/start: reset 3 cycles, start pulse -> core_reset high 4 cycles with clk_en=1, then low; busy=1 throughout.
//   - Done: core_out counts 0..20 then holds 210 -> done=1 exactly 8 cycles after the last change;
//     result=210, clk_en=0, busy=0; cycle_count=28 when RUN_CTRL_CYCLE_COUNT_EN is defined.
//   - Timeout: core_out toggles every cycle -> timeout=1 after 100 RUN cycles, done=0, result=last value, clk_en=0.
//   - Tie: MAX_CYCLES=20 with core_out frozen from RUN cycle 12 -> stable and watchdog coincide at cycle 20 -> done=1, timeout=0.
//   - Abort/restart: abort in RUN cycle 5 -> IDLE, core_reset=1, clk_en=0, result unchanged.
//     Start while busy -> ignored. Start in DONE -> done drops, new RST_HOLD.
//   - Sync reset during RUN -> next edge all outputs equal reset values; start afterwards runs normally.

Source files
------------

// File: rtl/rvmyth_run_ctrl_if.sv
// Handshake bundle between the top level and the rvmyth run sequencer.
// cycle_count exists only when RUN_CTRL_CYCLE_COUNT_EN is defined.
interface rvmyth_run_ctrl_if
`ifdef RUN_CTRL_CYCLE_COUNT_EN
  #(parameter int unsigned CNT_W = 16)
`endif
  ();

  logic       start;
  logic       abort;
  logic [9:0] core_out;
  logic       core_reset;
  logic       clk_en;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [9:0] result;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_count;
`endif

  modport master (
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    input  cycle_count,
`endif
    output start,
    output abort,
    output core_out,
    input  core_reset,
    input  clk_en,
    input  busy,
    input  done,
    input  timeout,
    input  result
  );

  modport slave (
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    output cycle_count,
`endif
    input  start,
    input  abort,
    input  core_out,
    output core_reset,
    output clk_en,
    output busy,
    output done,
    output timeout,
    output result
  );

endinterface

// File: rtl/rvmyth_run_ctrl.sv
// Run sequencer for the rvmyth core: reset hold, run until OUT settles or the watchdog fires.
// Optional RUN_CTRL_CYCLE_COUNT_EN adds a latched RUN-cycle count output.
module rvmyth_run_ctrl #(
  parameter int unsigned RST_CYCLES    = 10,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_CYCLES    = 10000,
  parameter int unsigned CNT_W         = 16
) (
  input logic              CLK,
  input logic              reset,
  rvmyth_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRstHold,
    StRun,
    StDone,
    StTimeout
  } state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] StabLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RunLast  = CNT_W'(MAX_CYCLES - 1);

  if (RST_CYCLES < 1) begin : gen_chk_rst
    $error("RST_CYCLES must be at least 1");
  end
  if (STABLE_CYCLES < 2) begin : gen_chk_stable
    $error("STABLE_CYCLES must be at least 2");
  end
  if (MAX_CYCLES <= STABLE_CYCLES) begin : gen_chk_max
    $error("MAX_CYCLES must exceed STABLE_CYCLES");
  end
  if (CNT_W < 32) begin : gen_chk_width
    if ((64'd1 << CNT_W) <= 64'(MAX_CYCLES)) begin : gen_chk_wrap
      $error("CNT_W too narrow for MAX_CYCLES");
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [9:0]       prev_out_q;
  logic [9:0]       result_q, result_d;
  logic             core_reset_q, core_reset_d;
  logic             clk_en_q, clk_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
`endif

  logic out_same;
  assign out_same = (bus.core_out == prev_out_q);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    run_cnt_d  = run_cnt_q;
    stab_cnt_d = stab_cnt_q;
    result_d   = result_q;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    cycle_count_d = cycle_count_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StRstHold;
          hold_cnt_d = '0;
        end
      end
      StRstHold: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = StRun;
          run_cnt_d  = '0;
          stab_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
          if (!out_same) begin
            stab_cnt_d = '0;
          end else if (stab_cnt_q != StabLast) begin
            stab_cnt_d = stab_cnt_q + CNT_W'(1);
          end
          // Settling is checked first so it wins a same-cycle tie with the watchdog.
          if (out_same && (stab_cnt_q == StabLast)) begin
            state_d  = StDone;
            result_d = bus.core_out;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
            cycle_count_d = run_cnt_q + CNT_W'(1);
`endif
          end else if (run_cnt_q == RunLast) begin
            state_d  = StTimeout;
            result_d = bus.core_out;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
            cycle_count_d = run_cnt_q + CNT_W'(1);
`endif
          end
        end
      end
      StDone, StTimeout: begin
        if (bus.start) begin
          state_d    = StRstHold;
          hold_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they land in registers with the state.
    core_reset_d = (state_d == StIdle) || (state_d == StRstHold);
    clk_en_d     = (state_d == StRstHold) || (state_d == StRun);
    busy_d       = clk_en_d;
    done_d       = (state_d == StDone);
    timeout_d    = (state_d == StTimeout);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_cnt_q   <= '0;
      run_cnt_q    <= '0;
      stab_cnt_q   <= '0;
      prev_out_q   <= '0;
      result_q     <= '0;
      core_reset_q <= 1'b1;
      clk_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      run_cnt_q    <= run_cnt_d;
      stab_cnt_q   <= stab_cnt_d;
      prev_out_q   <= bus.core_out;
      result_q     <= result_d;
      core_reset_q <= core_reset_d;
      clk_en_q     <= clk_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

`ifdef RUN_CTRL_CYCLE_COUNT_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      cycle_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.cycle_count = cycle_count_q;
`endif

  assign bus.core_reset = core_reset_q;
  assign bus.clk_en     = clk_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.result     = result_q;

endmodule

// File: tb/tb_rvmyth_run_ctrl.sv
// Bench for rvmyth_run_ctrl: vector table, directed corner sequences and random stimulus,
// two instances (watchdog 100 and 20) checked against a window-based reference model.
module tb_rvmyth_run_ctrl;

  localparam int R   = 4;
  localparam int S   = 8;
  localparam int WIN = S + 1;

  localparam int MIdle    = 0;
  localparam int MHold    = 1;
  localparam int MRun     = 2;
  localparam int MDone    = 3;
  localparam int MTimeout = 4;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  rvmyth_run_ctrl_if
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    #(.CNT_W(16))
`endif
    bus_m ();
  rvmyth_run_ctrl_if
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    #(.CNT_W(16))
`endif
    bus_t ();

  rvmyth_run_ctrl #(
    .RST_CYCLES(R), .STABLE_CYCLES(S), .MAX_CYCLES(100), .CNT_W(16)
  ) u_dut_main (
    .CLK(CLK), .reset(rst), .bus(bus_m)
  );

  rvmyth_run_ctrl #(
    .RST_CYCLES(R), .STABLE_CYCLES(S), .MAX_CYCLES(20), .CNT_W(16)
  ) u_dut_tie (
    .CLK(CLK), .reset(rst), .bus(bus_t)
  );

  // Model: a run is done once the newest S+1 OUT samples (oldest may be the last hold sample)
  // are identical; otherwise it times out after max_run RUN cycles.
  typedef struct {
    int                    mode;
    int                    hold_n;
    int                    run_n;
    int                    nsamp;
    logic [WIN-1:0][9:0]   win;
    logic [9:0]            result;
    int                    cyc;
  } model_t;

  typedef struct {
    logic       r;
    logic       st;
    logic       ab;
    logic [9:0] co;
    logic [4:0] exp_ctl;   // {core_reset, clk_en, busy, done, timeout}
    logic [9:0] exp_res;
  } vec_t;

  model_t mm, mt;
  int     n_cmp = 0;
  int     n_bad = 0;
  vec_t   vecs[13];

  function automatic model_t model_reset();
    model_t n;
    n.mode = MIdle; n.hold_n = 0; n.run_n = 0; n.nsamp = 0;
    n.win = '0; n.result = '0; n.cyc = 0;
    return n;
  endfunction

  function automatic bit window_settled(model_t m);
    if (m.nsamp < WIN) return 1'b0;
    for (int i = 1; i < WIN; i++) if (m.win[i] != m.win[0]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic model_t model_step(model_t m, int max_run, logic r, logic st, logic ab,
                                        logic [9:0] co);
    model_t n = m;
    if (r) return model_reset();
    case (m.mode)
      MIdle, MDone, MTimeout: begin
        if (st) begin n.mode = MHold; n.hold_n = 1; end
      end
      MHold: begin
        if (ab) n.mode = MIdle;
        else if (m.hold_n == R) begin
          n.mode = MRun; n.run_n = 0; n.nsamp = 1; n.win = '0; n.win[0] = co;
        end else n.hold_n = m.hold_n + 1;
      end
      MRun: begin
        if (ab) n.mode = MIdle;
        else begin
          n.run_n = m.run_n + 1;
          n.nsamp = m.nsamp + 1;
          n.win   = {m.win[WIN-2:0], co};
          if (window_settled(n)) begin
            n.mode = MDone; n.result = co; n.cyc = n.run_n;
          end else if (n.run_n == max_run) begin
            n.mode = MTimeout; n.result = co; n.cyc = n.run_n;
          end
        end
      end
      default: n.mode = MIdle;
    endcase
    return n;
  endfunction

  function automatic logic [14:0] model_vec(model_t m);
    logic cr, ce, bz, dn, to;
    cr = (m.mode == MIdle) || (m.mode == MHold);
    ce = (m.mode == MHold) || (m.mode == MRun);
    bz = ce;
    dn = (m.mode == MDone);
    to = (m.mode == MTimeout);
    return {cr, ce, bz, dn, to, m.result};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs to both DUTs, advance the models, compare 1 time unit after the edge.
  task automatic step_clk(input logic r, input logic st, input logic ab, input logic [9:0] co);
    rst = r;
    bus_m.start = st; bus_m.abort = ab; bus_m.core_out = co;
    bus_t.start = st; bus_t.abort = ab; bus_t.core_out = co;
    @(posedge CLK);
    mm = model_step(mm, 100, r, st, ab, co);
    mt = model_step(mt, 20, r, st, ab, co);
    #1;
    cmp("model_main", {bus_m.core_reset, bus_m.clk_en, bus_m.busy, bus_m.done, bus_m.timeout,
                       bus_m.result}, model_vec(mm));
    cmp("model_tie", {bus_t.core_reset, bus_t.clk_en, bus_t.busy, bus_t.done, bus_t.timeout,
                      bus_t.result}, model_vec(mt));
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    cmp("model_main_cyc", bus_m.cycle_count, mm.cyc);
    cmp("model_tie_cyc", bus_t.cycle_count, mt.cyc);
`endif
  endtask

  function automatic logic [4:0] flags_m();
    return {bus_m.done, bus_m.timeout, bus_m.clk_en, bus_m.busy, bus_m.core_reset};
  endfunction

  initial begin
    int         n;
    logic [9:0] tg;
    logic       r, st, ab;
    logic [9:0] co;

    mm = model_reset();
    mt = model_reset();

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10'd0, 5'b10000, 10'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 10'd0, 5'b10000, 10'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 10'd0, 5'b10000, 10'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 10'd0, 5'b11100, 10'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 10'd0, 5'b11100, 10'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 10'd0, 5'b11100, 10'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 10'd0, 5'b11100, 10'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 10'd0, 5'b01100, 10'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 10'd0, 5'b01100, 10'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 10'd0, 5'b10000, 10'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 10'd0, 5'b11100, 10'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 10'd0, 5'b10000, 10'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 10'd0, 5'b10000, 10'd0};

    foreach (vecs[i]) begin
      step_clk(vecs[i].r, vecs[i].st, vecs[i].ab, vecs[i].co);
      cmp($sformatf("vec%0d_ctl", i),
          {bus_m.core_reset, bus_m.clk_en, bus_m.busy, bus_m.done, bus_m.timeout},
          vecs[i].exp_ctl);
      cmp($sformatf("vec%0d_res", i), bus_m.result, vecs[i].exp_res);
    end

    // Settle: OUT counts through the end of reset hold into RUN, then sticks at 210.
    step_clk(0, 1, 0, 10'd0);
    for (int i = 0; i < 3; i++) step_clk(0, 0, 0, 10'd0);
    step_clk(0, 0, 0, 10'd1);
    for (int v = 2; v <= 20; v++) step_clk(0, 0, 0, 10'(v));
    step_clk(0, 0, 0, 10'd210);
    n = 0;
    while (!bus_m.done && n < 50) begin
      step_clk(0, 0, 0, 10'd210);
      n++;
    end
    cmp("done_latency", n, 8);
    cmp("done_result", bus_m.result, 10'd210);
    cmp("done_flags", flags_m(), 5'b10000);
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    cmp("done_cycles", bus_m.cycle_count, 28);
`endif

    // Restart from DONE, then OUT toggles forever so the watchdog fires.
    tg = 10'h155;
    step_clk(0, 1, 0, tg);
    cmp("restart_flags", flags_m(), 5'b00111);
    for (int i = 0; i < 4; i++) begin tg = ~tg; step_clk(0, 0, 0, tg); end
    n = 0;
    while (!bus_m.timeout && n < 150) begin
      tg = ~tg;
      step_clk(0, 0, 0, tg);
      n++;
    end
    cmp("timeout_latency", n, 100);
    cmp("timeout_result", bus_m.result, tg);
    cmp("timeout_flags", flags_m(), 5'b01000);

    // Tie on the 20-cycle watchdog instance: OUT frozen from RUN cycle 12.
    step_clk(0, 1, 0, tg);
    for (int i = 0; i < 4; i++) begin tg = ~tg; step_clk(0, 0, 0, tg); end
    for (int c = 1; c <= 20; c++) begin
      if (c < 12) tg = ~tg;
      else tg = 10'd300;
      step_clk(0, 0, 0, tg);
    end
    cmp("tie_done_timeout", {bus_t.done, bus_t.timeout}, 2'b10);
    cmp("tie_result", bus_t.result, 10'd300);

    // Abort in RUN cycle 5; start while busy is ignored.
    step_clk(0, 1, 0, 10'd5);
    for (int i = 0; i < 4; i++) step_clk(0, 0, 0, 10'd5);
    for (int c = 1; c <= 4; c++) step_clk(0, (c == 2 || c == 3), 0, 10'(c));
    cmp("busy_start_ignored", flags_m(), 5'b00110);
    step_clk(0, 0, 1, 10'd9);
    cmp("abort_flags", flags_m(), 5'b00001);
    cmp("abort_result", bus_m.result, 10'd300);

    // Synchronous reset mid-run, then a clean run.
    step_clk(0, 1, 0, 10'd7);
    for (int i = 0; i < 4; i++) step_clk(0, 0, 0, 10'd7);
    for (int i = 0; i < 3; i++) step_clk(0, 0, 0, 10'(i));
    step_clk(1, 0, 0, 10'd3);
    cmp("reset_flags", flags_m(), 5'b00001);
    cmp("reset_result", bus_m.result, 10'd0);
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    cmp("reset_cycles", bus_m.cycle_count, 0);
`endif
    step_clk(0, 1, 0, 10'd77);
    for (int i = 0; i < 4; i++) step_clk(0, 0, 0, 10'd77);
    n = 0;
    while (!bus_m.done && n < 30) begin
      step_clk(0, 0, 0, 10'd77);
      n++;
    end
    cmp("post_reset_latency", n, 8);
    cmp("post_reset_result", bus_m.result, 10'd77);
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    cmp("post_reset_cycles", bus_m.cycle_count, 8);
`endif

    // Random traffic against the model.
    co = 10'd0;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      st = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0) co = 10'($urandom_range(0, 3));
      step_clk(r, st, ab, co);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
